timer_ctrl: RTL and testbench

//  Control FSM for the countdown timer: edits the hr/min/sec preset from debounced buttons, then sequences the timer.

---
 rtl/timer_ctrl_pkg.sv | 42 ++++
 rtl/timer_ctrl_wrap_counter.sv | 25 ++
 rtl/timer_ctrl.sv | 163 ++++++++++++++++
 tb/tb_timer_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared codes and widths for the countdown timer slice.
// Used by the control FSM, the timer datapath and the display mux.
package timer_ctrl_pkg;

  localparam int HR_W        = 5;
  localparam int MS_W        = 6;
  localparam int MIN_SEC_MAX = 59;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    F_HR  = 2'd0,
    F_MIN = 2'd1,
    F_SEC = 2'd2
  } field_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_CLEAR,
    EV_DONE,
    EV_PAUSE,
    EV_START,
    EV_SEL,
    EV_INC
  } ev_t;

  function automatic field_t next_field(
    input field_t f
  );
    unique case (f)
      F_HR:    return F_MIN;
      F_MIN:   return F_SEC;
      default: return F_HR;
    endcase
  endfunction

endpackage

// File: rtl/timer_ctrl_wrap_counter.sv
// Preset field counter: increments on inc, wraps MAX->0.
// clr and rst both zero the value.
module wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc) begin
      if (value == W'(MAX))
        value <= '0;
      else
        value <= value + W'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer control: preset editing, run/pause sequencing
// and a tick-timed alarm once the timer reports done.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int HR_MAX     = 23,
  parameter int ALARM_SECS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_1hz,
  input  logic            btn_start,
  input  logic            btn_pause,
  input  logic            btn_clear,
  input  logic            btn_sel,
  input  logic            btn_inc,
  input  logic            timer_done,
  output logic [HR_W-1:0] set_hr,
  output logic [MS_W-1:0] set_min,
  output logic [MS_W-1:0] set_sec,
  output logic            tm_load,
  output logic            tm_run,
  output logic            alarm,
  output logic [1:0]      state,
  output logic [1:0]      sel_field
);

  state_t      st_q;
  field_t      fld_q;
  logic [5:0]  alarm_cnt;
  ev_t         ev;
  logic        in_idle;
  logic        preset_nz;
  logic        clr_preset;
  logic        inc_hr;
  logic        inc_min;
  logic        inc_sec;

  assign state     = st_q;
  assign sel_field = fld_q;

  // timer_done only matters while counting
  always_comb begin
    ev = EV_NONE;
    if (btn_clear)
      ev = EV_CLEAR;
    else if (timer_done && st_q == S_RUN)
      ev = EV_DONE;
    else if (btn_pause)
      ev = EV_PAUSE;
    else if (btn_start)
      ev = EV_START;
    else if (btn_sel)
      ev = EV_SEL;
    else if (btn_inc)
      ev = EV_INC;
  end

  assign in_idle    = (st_q == S_IDLE);
  assign preset_nz  = |{set_hr, set_min, set_sec};
  assign clr_preset = in_idle && ev == EV_CLEAR;
  assign inc_hr     = in_idle && ev == EV_INC
                      && fld_q == F_HR;
  assign inc_min    = in_idle && ev == EV_INC
                      && fld_q == F_MIN;
  assign inc_sec    = in_idle && ev == EV_INC
                      && fld_q == F_SEC;

  wrap_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_hr),
    .clr   (clr_preset),
    .value (set_hr)
  );

  wrap_counter #(.W(MS_W), .MAX(MIN_SEC_MAX)) u_min (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_min),
    .clr   (clr_preset),
    .value (set_min)
  );

  wrap_counter #(.W(MS_W), .MAX(MIN_SEC_MAX)) u_sec (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_sec),
    .clr   (clr_preset),
    .value (set_sec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      fld_q     <= F_HR;
      tm_load   <= 1'b0;
      tm_run    <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      tm_load <= 1'b0;
      unique case (st_q)
        S_IDLE: begin
          tm_run <= 1'b0;
          alarm  <= 1'b0;
          if (ev == EV_CLEAR) begin
            fld_q <= F_HR;
          end else if (ev == EV_START && preset_nz) begin
            tm_load <= 1'b1;
            st_q    <= S_RUN;
          end else if (ev == EV_SEL) begin
            fld_q <= next_field(fld_q);
          end
        end
        S_RUN: begin
          if (ev == EV_CLEAR) begin
            st_q   <= S_IDLE;
            tm_run <= 1'b0;
          end else if (ev == EV_DONE) begin
            st_q      <= S_ALARM;
            tm_run    <= 1'b0;
            alarm     <= 1'b1;
            alarm_cnt <= 6'(ALARM_SECS);
          end else if (ev == EV_PAUSE) begin
            st_q   <= S_PAUSE;
            tm_run <= 1'b0;
          end else begin
            tm_run <= 1'b1;
          end
        end
        S_PAUSE: begin
          tm_run <= 1'b0;
          if (ev == EV_CLEAR) begin
            st_q <= S_IDLE;
          end else if (ev == EV_START) begin
            st_q   <= S_RUN;
            tm_run <= 1'b1;
          end
        end
        default: begin
          tm_run <= 1'b0;
          // any of start/pause/clear acknowledges the alarm
          if (ev == EV_CLEAR || ev == EV_PAUSE
              || ev == EV_START) begin
            st_q      <= S_IDLE;
            alarm     <= 1'b0;
            alarm_cnt <= '0;
          end else if (tick_1hz) begin
            if (alarm_cnt <= 6'd1) begin
              st_q      <= S_IDLE;
              alarm     <= 1'b0;
              alarm_cnt <= '0;
            end else begin
              alarm_cnt <= alarm_cnt - 6'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: preset edit, run/pause,
// alarm timing/ack, priority corner cases and mid-run reset.
module tb_timer_ctrl;

  localparam int INC   = 1;
  localparam int SEL   = 2;
  localparam int START = 4;
  localparam int PAUSE = 8;
  localparam int CLEAR = 16;
  localparam int TICK  = 32;
  localparam int DONE  = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_sel = 1'b0;
  logic       btn_inc = 1'b0;
  logic       timer_done = 1'b0;
  logic [4:0] set_hr;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       tm_load;
  logic       tm_run;
  logic       alarm;
  logic [1:0] state;
  logic [1:0] sel_field;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  timer_ctrl #(.HR_MAX(23), .ALARM_SECS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .btn_start  (btn_start),
    .btn_pause  (btn_pause),
    .btn_clear  (btn_clear),
    .btn_sel    (btn_sel),
    .btn_inc    (btn_inc),
    .timer_done (timer_done),
    .set_hr     (set_hr),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .tm_load    (tm_load),
    .tm_run     (tm_run),
    .alarm      (alarm),
    .state      (state),
    .sel_field  (sel_field)
  );

  // drive for one posedge, then return at the following negedge
  task automatic cyc(input int v);
    btn_inc    = v[0];
    btn_sel    = v[1];
    btn_start  = v[2];
    btn_pause  = v[3];
    btn_clear  = v[4];
    tick_1hz   = v[5];
    timer_done = v[6];
    @(negedge clk);
    {btn_inc, btn_sel, btn_start, btn_pause} = 4'b0;
    {btn_clear, tick_1hz, timer_done} = 3'b0;
  endtask

  task automatic rep(input int v, input int n);
    for (int i = 0; i < n; i++) cyc(v);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input int st,
                         input int ld, input int run,
                         input int al);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".load"}, 32'(tm_load), 32'(ld));
    chk({tag, ".run"}, 32'(tm_run), 32'(run));
    chk({tag, ".alarm"}, 32'(alarm), 32'(al));
  endtask

  task automatic chk_set(input string tag, input int h,
                         input int m, input int s);
    chk({tag, ".hr"}, 32'(set_hr), 32'(h));
    chk({tag, ".min"}, 32'(set_min), 32'(m));
    chk({tag, ".sec"}, 32'(set_sec), 32'(s));
  endtask

  initial begin
    // 1. reset and zero-preset start
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_ctl("rst", 0, 0, 0, 0);
    chk_set("rst", 0, 0, 0);
    chk("rst.sel", 32'(sel_field), 0);
    cyc(START);
    chk_ctl("zstart", 0, 0, 0, 0);

    // 2. preset editing and wraps
    rep(SEL, 2);
    chk("sel2", 32'(sel_field), 2);
    rep(INC, 5);
    rep(SEL, 2);
    chk("sel_min", 32'(sel_field), 1);
    rep(INC, 61);
    chk_set("edit", 0, 1, 5);
    rep(SEL, 2);
    chk("sel_hr", 32'(sel_field), 0);
    rep(SEL, 4);
    chk("sel4", 32'(sel_field), 1);
    rep(SEL, 2);
    rep(INC, 24);
    chk("hr_wrap", 32'(set_hr), 0);
    rep(SEL, 1);
    rep(INC, 59);
    chk_set("p5", 0, 0, 5);

    // 3. start, pause, resume
    cyc(START);
    chk_ctl("load", 1, 1, 0, 0);
    cyc(0);
    chk_ctl("run", 1, 0, 1, 0);
    cyc(PAUSE);
    chk_ctl("pause", 2, 0, 0, 0);
    cyc(PAUSE);
    chk_ctl("pause2", 2, 0, 0, 0);
    cyc(START);
    chk_ctl("resume", 1, 0, 1, 0);

    // 4. alarm: entry tick ignored, then 10 ticks
    cyc(DONE | TICK);
    chk_ctl("alarm", 3, 0, 0, 1);
    rep(TICK, 9);
    chk_ctl("al9", 3, 0, 0, 1);
    cyc(TICK);
    chk_ctl("al10", 0, 0, 0, 0);
    chk_set("al_keep", 0, 0, 5);
    cyc(START);
    cyc(0);
    cyc(DONE);
    rep(TICK, 3);
    chk_ctl("al3", 3, 0, 0, 1);
    cyc(START);
    chk_ctl("ack", 0, 0, 0, 0);

    // 5. priority corners
    cyc(START);
    cyc(0);
    cyc(CLEAR | DONE);
    chk_ctl("clr_done", 0, 0, 0, 0);
    chk_set("clr_keep", 0, 0, 5);
    cyc(START);
    cyc(0);
    cyc(START | PAUSE);
    chk_ctl("st_pa", 2, 0, 0, 0);
    cyc(CLEAR);
    chk_ctl("pa_clr", 0, 0, 0, 0);
    chk_set("pa_keep", 0, 0, 5);

    // 6. frozen preset in RUN, reset mid-RUN/ALARM
    cyc(START);
    cyc(0);
    cyc(SEL);
    cyc(INC);
    chk_set("frozen", 0, 0, 5);
    chk("fsel", 32'(sel_field), 1);
    chk_ctl("frun", 1, 0, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_ctl("rst_run", 0, 0, 0, 0);
    chk_set("rst_run", 0, 0, 0);
    cyc(INC);
    chk("hr1", 32'(set_hr), 1);
    cyc(START);
    cyc(0);
    cyc(DONE);
    chk_ctl("al_b", 3, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_ctl("rst_al", 0, 0, 0, 0);
    chk_set("rst_al", 0, 0, 0);

    // IDLE clear zeroes preset and cursor
    cyc(SEL);
    cyc(INC);
    chk_set("pre_clr", 0, 1, 0);
    cyc(CLEAR);
    chk_set("idle_clr", 0, 0, 0);
    chk("clr_sel", 32'(sel_field), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
